// File: rtl/forwarding_execute.sv
// Execute-stage operand forwarding: each operand picks EX/MEM, MEM/WB, its hold
// register, or DE/EX data, and the hold register keeps a forwarded value alive across stalls.

module fwd_operand #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  de_data_i,
    input  logic          ex_en_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [W-1:0]  ex_data_i,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [W-1:0]  wb_data_i,
    output logic [W-1:0]  fwd_data_o,
    output logic          hold_vld_o
);
    logic          ex_hit;
    logic          wb_hit;
    logic          live;
    logic [W-1:0]  live_val;
    logic [W-1:0]  hold_q;
    logic [W-1:0]  hold_d;
    logic          vld_q;
    logic          vld_d;

    assign ex_hit   = ex_en_i && (ex_addr_i == addr_i) && (addr_i != '0);
    assign wb_hit   = wb_en_i && (wb_addr_i == addr_i) && (addr_i != '0);
    assign live     = ex_hit || wb_hit;
    assign live_val = ex_hit ? ex_data_i : wb_data_i;

    // A live match is never older than the held producer, so it wins over the hold.
    assign fwd_data_o = live ? live_val : (vld_q ? hold_q : de_data_i);
    assign hold_vld_o = vld_q;

    always_comb begin
        vld_d  = 1'b0;
        hold_d = hold_q;
        if (stall_i && !flush_i) begin
            vld_d = vld_q;
            if (live) begin
                vld_d  = 1'b1;
                hold_d = live_val;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            vld_q  <= vld_d;
            hold_q <= hold_d;
        end
    end
endmodule

module forwarding_execute #(
    parameter int S_WIDTH = 32,
    parameter int V_WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EX_stall,
    input  logic               EX_flush,
    input  logic [4:0]         DE_EX_S1_address,
    input  logic [4:0]         DE_EX_S2_address,
    input  logic [3:0]         DE_EX_V1_address,
    input  logic [3:0]         DE_EX_V2_address,
    input  logic [S_WIDTH-1:0] DE_EX_S1_data,
    input  logic [S_WIDTH-1:0] DE_EX_S2_data,
    input  logic [V_WIDTH-1:0] DE_EX_V1_data,
    input  logic [V_WIDTH-1:0] DE_EX_V2_data,
    input  logic               EX_MEM_Swb_en,
    input  logic [4:0]         EX_MEM_Swb_address,
    input  logic [S_WIDTH-1:0] EX_MEM_S_result,
    input  logic               EX_MEM_Vwb_en,
    input  logic [3:0]         EX_MEM_Vwb_address,
    input  logic [V_WIDTH-1:0] EX_MEM_V_result,
    input  logic               MEM_WB_Swb_en,
    input  logic [4:0]         MEM_WB_Swb_address,
    input  logic [S_WIDTH-1:0] MEM_WB_S_data,
    input  logic               MEM_WB_Vwb_en,
    input  logic [3:0]         MEM_WB_Vwb_address,
    input  logic [V_WIDTH-1:0] MEM_WB_V_data,
    output logic [S_WIDTH-1:0] EX_S1_data,
    output logic [S_WIDTH-1:0] EX_S2_data,
    output logic [V_WIDTH-1:0] EX_V1_data,
    output logic [V_WIDTH-1:0] EX_V2_data,
    output logic [3:0]         EX_hold_valid
);
    fwd_operand #(.W(S_WIDTH), .AW(5)) u_s1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(EX_stall), .flush_i(EX_flush),
        .addr_i(DE_EX_S1_address), .de_data_i(DE_EX_S1_data),
        .ex_en_i(EX_MEM_Swb_en), .ex_addr_i(EX_MEM_Swb_address), .ex_data_i(EX_MEM_S_result),
        .wb_en_i(MEM_WB_Swb_en), .wb_addr_i(MEM_WB_Swb_address), .wb_data_i(MEM_WB_S_data),
        .fwd_data_o(EX_S1_data), .hold_vld_o(EX_hold_valid[0])
    );

    fwd_operand #(.W(S_WIDTH), .AW(5)) u_s2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(EX_stall), .flush_i(EX_flush),
        .addr_i(DE_EX_S2_address), .de_data_i(DE_EX_S2_data),
        .ex_en_i(EX_MEM_Swb_en), .ex_addr_i(EX_MEM_Swb_address), .ex_data_i(EX_MEM_S_result),
        .wb_en_i(MEM_WB_Swb_en), .wb_addr_i(MEM_WB_Swb_address), .wb_data_i(MEM_WB_S_data),
        .fwd_data_o(EX_S2_data), .hold_vld_o(EX_hold_valid[1])
    );

    // Vector operands only ever see the vector writeback ports.
    fwd_operand #(.W(V_WIDTH), .AW(4)) u_v1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(EX_stall), .flush_i(EX_flush),
        .addr_i(DE_EX_V1_address), .de_data_i(DE_EX_V1_data),
        .ex_en_i(EX_MEM_Vwb_en), .ex_addr_i(EX_MEM_Vwb_address), .ex_data_i(EX_MEM_V_result),
        .wb_en_i(MEM_WB_Vwb_en), .wb_addr_i(MEM_WB_Vwb_address), .wb_data_i(MEM_WB_V_data),
        .fwd_data_o(EX_V1_data), .hold_vld_o(EX_hold_valid[2])
    );

    fwd_operand #(.W(V_WIDTH), .AW(4)) u_v2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(EX_stall), .flush_i(EX_flush),
        .addr_i(DE_EX_V2_address), .de_data_i(DE_EX_V2_data),
        .ex_en_i(EX_MEM_Vwb_en), .ex_addr_i(EX_MEM_Vwb_address), .ex_data_i(EX_MEM_V_result),
        .wb_en_i(MEM_WB_Vwb_en), .wb_addr_i(MEM_WB_Vwb_address), .wb_data_i(MEM_WB_V_data),
        .fwd_data_o(EX_V2_data), .hold_vld_o(EX_hold_valid[3])
    );
endmodule

// File: tb/tb_forwarding_execute.sv
// Scoreboard bench for forwarding_execute: directed vectors push expected operands,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_forwarding_execute;
    localparam logic [31:0]  DS1 = 32'h0000_1001;
    localparam logic [31:0]  DS2 = 32'h0000_2002;
    localparam logic [127:0] DV1 = {4{32'h3003_3003}};
    localparam logic [127:0] DV2 = {4{32'h4004_4004}};
    localparam logic [127:0] VA5 = {16{8'hA5}};
    localparam logic [127:0] V5A = {16{8'h5A}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         EX_stall, EX_flush;
    logic [4:0]   DE_EX_S1_address, DE_EX_S2_address;
    logic [3:0]   DE_EX_V1_address, DE_EX_V2_address;
    logic [31:0]  DE_EX_S1_data, DE_EX_S2_data;
    logic [127:0] DE_EX_V1_data, DE_EX_V2_data;
    logic         EX_MEM_Swb_en, EX_MEM_Vwb_en, MEM_WB_Swb_en, MEM_WB_Vwb_en;
    logic [4:0]   EX_MEM_Swb_address, MEM_WB_Swb_address;
    logic [3:0]   EX_MEM_Vwb_address, MEM_WB_Vwb_address;
    logic [31:0]  EX_MEM_S_result, MEM_WB_S_data;
    logic [127:0] EX_MEM_V_result, MEM_WB_V_data;
    logic [31:0]  EX_S1_data, EX_S2_data;
    logic [127:0] EX_V1_data, EX_V2_data;
    logic [3:0]   EX_hold_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        tag;
        logic [31:0]  s1;
        logic [31:0]  s2;
        logic [127:0] v1;
        logic [127:0] v2;
        logic [3:0]   hv;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    forwarding_execute #(.S_WIDTH(32), .V_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .EX_stall(EX_stall), .EX_flush(EX_flush),
        .DE_EX_S1_address(DE_EX_S1_address), .DE_EX_S2_address(DE_EX_S2_address),
        .DE_EX_V1_address(DE_EX_V1_address), .DE_EX_V2_address(DE_EX_V2_address),
        .DE_EX_S1_data(DE_EX_S1_data), .DE_EX_S2_data(DE_EX_S2_data),
        .DE_EX_V1_data(DE_EX_V1_data), .DE_EX_V2_data(DE_EX_V2_data),
        .EX_MEM_Swb_en(EX_MEM_Swb_en), .EX_MEM_Swb_address(EX_MEM_Swb_address),
        .EX_MEM_S_result(EX_MEM_S_result),
        .EX_MEM_Vwb_en(EX_MEM_Vwb_en), .EX_MEM_Vwb_address(EX_MEM_Vwb_address),
        .EX_MEM_V_result(EX_MEM_V_result),
        .MEM_WB_Swb_en(MEM_WB_Swb_en), .MEM_WB_Swb_address(MEM_WB_Swb_address),
        .MEM_WB_S_data(MEM_WB_S_data),
        .MEM_WB_Vwb_en(MEM_WB_Vwb_en), .MEM_WB_Vwb_address(MEM_WB_Vwb_address),
        .MEM_WB_V_data(MEM_WB_V_data),
        .EX_S1_data(EX_S1_data), .EX_S2_data(EX_S2_data),
        .EX_V1_data(EX_V1_data), .EX_V2_data(EX_V2_data),
        .EX_hold_valid(EX_hold_valid)
    );

    task automatic cmp(input string tag, input string fld, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", tag, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.tag, "S1", {96'd0, EX_S1_data}, {96'd0, e.s1});
            cmp(e.tag, "S2", {96'd0, EX_S2_data}, {96'd0, e.s2});
            cmp(e.tag, "V1", EX_V1_data, e.v1);
            cmp(e.tag, "V2", EX_V2_data, e.v2);
            cmp(e.tag, "hold_valid", {124'd0, EX_hold_valid}, {124'd0, e.hv});
        end
    end

    task automatic expect_out(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [127:0] v1, input logic [127:0] v2, input logic [3:0] hv);
        exp_t e;
        e.tag = tag; e.s1 = s1; e.s2 = s2; e.v1 = v1; e.v2 = v2; e.hv = hv;
        sb.push_back(e);
    endtask

    task automatic clear_wb();
        EX_MEM_Swb_en = 0; EX_MEM_Swb_address = 0; EX_MEM_S_result = 0;
        EX_MEM_Vwb_en = 0; EX_MEM_Vwb_address = 0; EX_MEM_V_result = 0;
        MEM_WB_Swb_en = 0; MEM_WB_Swb_address = 0; MEM_WB_S_data = 0;
        MEM_WB_Vwb_en = 0; MEM_WB_Vwb_address = 0; MEM_WB_V_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; EX_stall = 0; EX_flush = 0;
        DE_EX_S1_address = 5'd3; DE_EX_S2_address = 5'd4;
        DE_EX_V1_address = 4'd1; DE_EX_V2_address = 4'd5;
        DE_EX_S1_data = DS1; DE_EX_S2_data = DS2;
        DE_EX_V1_data = DV1; DE_EX_V2_data = DV2;
        clear_wb();
        #1;
        expect_out("reset", DS1, DS2, DV1, DV2, 4'b0000);
        @(negedge clk); #1 rst_n = 1;

        step();
        expect_out("no_hazard", DS1, DS2, DV1, DV2, 4'b0000);

        step();
        DE_EX_S2_address = 5'd5;
        EX_MEM_Swb_en = 1; EX_MEM_Swb_address = 5'd5; EX_MEM_S_result = 32'h11;
        MEM_WB_Swb_en = 1; MEM_WB_Swb_address = 5'd5; MEM_WB_S_data = 32'h22;
        expect_out("dbl_prod", DS1, 32'h11, DV1, DV2, 4'b0000);

        step();
        EX_MEM_Swb_en = 0;
        expect_out("dbl_prod_wb", DS1, 32'h22, DV1, DV2, 4'b0000);

        step();
        clear_wb();
        DE_EX_S2_address = 5'd4; DE_EX_S1_address = 5'd0;
        EX_MEM_Swb_en = 1; EX_MEM_Swb_address = 5'd0; EX_MEM_S_result = 32'hFFFF;
        MEM_WB_Swb_en = 1; MEM_WB_Swb_address = 5'd0; MEM_WB_S_data = 32'h1234;
        expect_out("zero_reg", DS1, DS2, DV1, DV2, 4'b0000);

        // Stall drain: producer in EX/MEM, then MEM/WB, then retired.
        step();
        clear_wb();
        DE_EX_S1_address = 5'd3; DE_EX_V1_address = 4'd2; EX_stall = 1;
        EX_MEM_Vwb_en = 1; EX_MEM_Vwb_address = 4'd2; EX_MEM_V_result = VA5;
        expect_out("drain_c0", DS1, DS2, VA5, DV2, 4'b0000);
        step();
        clear_wb();
        MEM_WB_Vwb_en = 1; MEM_WB_Vwb_address = 4'd2; MEM_WB_V_data = VA5;
        expect_out("drain_c1", DS1, DS2, VA5, DV2, 4'b0100);
        step();
        clear_wb();
        expect_out("drain_c2", DS1, DS2, VA5, DV2, 4'b0100);
        step();
        expect_out("drain_c3", DS1, DS2, VA5, DV2, 4'b0100);
        step();
        EX_stall = 0;
        expect_out("drain_rel", DS1, DS2, VA5, DV2, 4'b0100);
        step();
        expect_out("after_rel", DS1, DS2, DV1, DV2, 4'b0000);

        // Flush overrides stall.
        step();
        DE_EX_V1_address = 4'd1; DE_EX_S1_address = 5'd7; EX_stall = 1;
        EX_MEM_Swb_en = 1; EX_MEM_Swb_address = 5'd7; EX_MEM_S_result = 32'h77;
        expect_out("flush_c0", 32'h77, DS2, DV1, DV2, 4'b0000);
        step();
        clear_wb();
        EX_flush = 1;
        expect_out("flush_c1", 32'h77, DS2, DV1, DV2, 4'b0001);
        step();
        EX_flush = 0; EX_stall = 0;
        expect_out("flush_after", DS1, DS2, DV1, DV2, 4'b0000);

        // Scalar and vector paths do not cross.
        step();
        DE_EX_S1_address = 5'd3; DE_EX_V1_address = 4'd2;
        EX_MEM_Swb_en = 1; EX_MEM_Swb_address = 5'd2; EX_MEM_S_result = 32'hDEAD;
        MEM_WB_Vwb_en = 1; MEM_WB_Vwb_address = 4'd3; MEM_WB_V_data = {4{32'hBEEF_0000}};
        expect_out("isolation", DS1, DS2, DV1, DV2, 4'b0000);

        // Reset asserted while a hold is active.
        step();
        clear_wb();
        DE_EX_V2_address = 4'd4; EX_stall = 1;
        EX_MEM_Vwb_en = 1; EX_MEM_Vwb_address = 4'd4; EX_MEM_V_result = V5A;
        expect_out("rms_c0", DS1, DS2, DV1, V5A, 4'b0000);
        step();
        clear_wb();
        expect_out("rms_c1", DS1, DS2, DV1, V5A, 4'b1000);
        step();
        rst_n = 0;
        expect_out("rms_rst", DS1, DS2, DV1, DV2, 4'b0000);
        step();
        rst_n = 1; EX_stall = 0;
        expect_out("post_rst", DS1, DS2, DV1, DV2, 4'b0000);

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
